// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Bridges the execute stage and a big-endian byte memory (DynamicMemory).
//   It provides the RV32I loads LB/LH/LW/LBU/LHU and stores SB/SH/SW over a
//   valid/ready request and a one-cycle response pulse. It checks funct3
//   legality, natural alignment and address range before it touches memory.
//   The memory can only write bytes (000) or words (010), so a halfword store
//   is split into two byte writes: high byte at addr, low byte at addr+1.
//
// Ports:
//   CLK, RST     clock and synchronous active-high reset
//   REQ_*        request channel (VALID/READY, WE, FUNCT3, ADDR, WDATA)
//   RESP_*       completion pulse, extended load data, error flag
//   MEM_*        DynamicMemory write enable, funct3, address, write data,
//                and its asynchronous read data
// ============================================================================
module load_store_unit #(
    parameter int MEM_BYTES = 1025
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [2:0]  REQ_FUNCT3,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,

    output logic        RESP_VALID,
    output logic [31:0] RESP_RDATA,
    output logic        RESP_ERR,

    output logic        MEM_WE,
    output logic [2:0]  MEM_FUNCT3,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA
);

    localparam logic [32:0] LAST_ADDR = 33'(MEM_BYTES - 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ST0,
        S_ST1,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [7:0]  r_wdata_lo;

    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_mem_we;
    logic [2:0]  r_mem_funct3;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_accept;
    logic [32:0] w_size;
    logic [32:0] w_last;
    logic        w_f3_ok;
    logic        w_align_ok;
    logic        w_range_ok;
    logic        w_legal;

    // Memory returns the byte at MEM_ADDR in bits [31:24], so narrow loads
    // always take the top of the read word.
    function automatic logic [31:0] f_load_extend(input logic [2:0]  f3,
                                                  input logic [31:0] d);
        logic [31:0] v;
        case (f3)
            F3_B:    v = {{24{d[31]}}, d[31:24]};
            F3_H:    v = {{16{d[31]}}, d[31:16]};
            F3_BU:   v = {24'b0, d[31:24]};
            F3_HU:   v = {16'b0, d[31:16]};
            default: v = d;
        endcase
        return v;
    endfunction

    // Data for the first store cycle. SH sends its high byte first so that
    // it lands at the lower (big-endian most significant) address.
    function automatic logic [31:0] f_first_wdata(input logic [2:0]  f3,
                                                  input logic [31:0] wd);
        logic [31:0] v;
        case (f3)
            F3_W:    v = wd;
            F3_H:    v = {24'b0, wd[15:8]};
            default: v = {24'b0, wd[7:0]};
        endcase
        return v;
    endfunction

    assign REQ_READY = (r_state == S_IDLE) && !RST;
    assign w_accept  = REQ_VALID && REQ_READY;

    always_comb begin
        case (REQ_FUNCT3[1:0])
            2'b01:   w_size = 33'd2;
            2'b10:   w_size = 33'd4;
            default: w_size = 33'd1;
        endcase

        // 33-bit sum so an address near 2^32 cannot wrap back into range.
        w_last = {1'b0, REQ_ADDR} + w_size - 33'd1;

        if (REQ_WE) begin
            w_f3_ok = (REQ_FUNCT3 == F3_B) || (REQ_FUNCT3 == F3_H) ||
                      (REQ_FUNCT3 == F3_W);
        end else begin
            w_f3_ok = (REQ_FUNCT3 == F3_B)  || (REQ_FUNCT3 == F3_H)  ||
                      (REQ_FUNCT3 == F3_W)  || (REQ_FUNCT3 == F3_BU) ||
                      (REQ_FUNCT3 == F3_HU);
        end

        case (REQ_FUNCT3[1:0])
            2'b01:   w_align_ok = !REQ_ADDR[0];
            2'b10:   w_align_ok = (REQ_ADDR[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase

        w_range_ok = (w_last <= LAST_ADDR);
        w_legal    = w_f3_ok && w_align_ok && w_range_ok;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'b0;
            r_resp_err   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_funct3 <= 3'b000;
            r_mem_addr   <= 32'b0;
            r_mem_wdata  <= 32'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= 32'b0;
                    r_resp_err   <= 1'b0;
                    if (w_accept) begin
                        r_funct3   <= REQ_FUNCT3;
                        r_addr     <= REQ_ADDR;
                        r_wdata_lo <= REQ_WDATA[7:0];
                        if (!w_legal) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (!REQ_WE) begin
                            r_state    <= S_LOAD;
                            r_mem_addr <= REQ_ADDR;
                        end else begin
                            r_state      <= S_ST0;
                            r_mem_we     <= 1'b1;
                            r_mem_funct3 <= (REQ_FUNCT3 == F3_W) ? F3_W : F3_B;
                            r_mem_addr   <= REQ_ADDR;
                            r_mem_wdata  <= f_first_wdata(REQ_FUNCT3, REQ_WDATA);
                        end
                    end
                end

                S_LOAD: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= f_load_extend(r_funct3, MEM_RDATA);
                    r_mem_addr   <= 32'b0;
                end

                S_ST0: begin
                    if (r_funct3 == F3_H) begin
                        // Second half of SH: low byte to the next address.
                        r_state      <= S_ST1;
                        r_mem_we     <= 1'b1;
                        r_mem_funct3 <= F3_B;
                        r_mem_addr   <= r_addr + 32'd1;
                        r_mem_wdata  <= {24'b0, r_wdata_lo};
                    end else begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_funct3 <= 3'b000;
                        r_mem_addr   <= 32'b0;
                        r_mem_wdata  <= 32'b0;
                    end
                end

                S_ST1: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'b0;
                    r_mem_we     <= 1'b0;
                    r_mem_funct3 <= 3'b000;
                    r_mem_addr   <= 32'b0;
                    r_mem_wdata  <= 32'b0;
                end

                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= 32'b0;
                    r_resp_err   <= 1'b0;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= 32'b0;
                    r_resp_err   <= 1'b0;
                    r_mem_we     <= 1'b0;
                    r_mem_funct3 <= 3'b000;
                    r_mem_addr   <= 32'b0;
                    r_mem_wdata  <= 32'b0;
                end
            endcase
        end
    end

    // RST masks the write enable and the response in the same cycle, so a
    // reset during ST1 stops the low-byte write at that very edge and a
    // reset during RESP never shows a completion.
    assign MEM_WE     = r_mem_we && !RST;
    assign MEM_FUNCT3 = r_mem_funct3;
    assign MEM_ADDR   = r_mem_addr;
    assign MEM_WDATA  = r_mem_wdata;

    assign RESP_VALID = r_resp_valid && !RST;
    assign RESP_RDATA = RST ? 32'b0 : r_resp_rdata;
    assign RESP_ERR   = r_resp_err && !RST;

endmodule

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit
// ----------------------------------------------------------------------------
// Directed bench for load_store_unit with a behavioural big-endian byte
// memory. Stimulus pushes expected responses and expected memory writes into
// queues; a monitor on the falling edge pops and compares them.
// ============================================================================
module tb_load_store_unit;

    localparam int MEM_BYTES = 1025;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WE = 1'b0;
    logic [2:0]  REQ_FUNCT3 = 3'b000;
    logic [31:0] REQ_ADDR = 32'b0;
    logic [31:0] REQ_WDATA = 32'b0;
    logic        RESP_VALID;
    logic [31:0] RESP_RDATA;
    logic        RESP_ERR;
    logic        MEM_WE;
    logic [2:0]  MEM_FUNCT3;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR),
        .MEM_WE(MEM_WE), .MEM_FUNCT3(MEM_FUNCT3), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- behavioural DynamicMemory ----------------
    logic [7:0] mem [0:MEM_BYTES-1];
    logic       tb_init = 1'b1;

    always_comb begin
        logic [31:0] idx;
        MEM_RDATA = 32'b0;
        idx = 32'b0;
        for (int k = 0; k < 4; k++) begin
            idx = MEM_ADDR + 32'(k);
            MEM_RDATA[31-8*k -: 8] = (idx < 32'(MEM_BYTES)) ? mem[idx[10:0]] : 8'h00;
        end
    end

    always @(posedge CLK) begin
        if (tb_init) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
        end else if (MEM_WE) begin
            if (MEM_FUNCT3 == 3'b010) begin
                for (int k = 0; k < 4; k++)
                    if (MEM_ADDR + 32'(k) < 32'(MEM_BYTES))
                        mem[10'(MEM_ADDR) + 11'(k)] <= MEM_WDATA[31-8*k -: 8];
            end else if (MEM_FUNCT3 == 3'b000) begin
                if (MEM_ADDR < 32'(MEM_BYTES)) mem[MEM_ADDR[10:0]] <= MEM_WDATA[7:0];
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc0;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
    } wr_t;

    resp_t exp_q[$];
    wr_t   wr_q[$];
    int    errors = 0;
    int    checks = 0;
    logic  mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    resp_t e;
    wr_t   w;
    always @(negedge CLK) begin
        if (mon_en) begin
            if (RESP_VALID) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got err=%0b rdata=%0h expected none", RESP_ERR, RESP_RDATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_err", 64'(RESP_ERR), 64'(e.err));
                    chk("resp_rdata", 64'(RESP_RDATA), 64'(e.rdata));
                    chk("resp_latency", 64'(cyc - e.cyc0), 64'(e.lat));
                end
            end else if (!RST) begin
                chk("resp_idle_zero", {31'b0, RESP_ERR, RESP_RDATA}, 64'b0);
            end
            if (MEM_WE) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr=%0h f3=%0b data=%0h expected none",
                             MEM_ADDR, MEM_FUNCT3, MEM_WDATA);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 64'(MEM_ADDR), 64'(w.addr));
                    chk("wr_funct3", 64'(MEM_FUNCT3), 64'(w.f3));
                    chk("wr_data", 64'(MEM_WDATA), 64'(w.wdata));
                end
            end else if (!RST) begin
                chk("mem_idle_zero", {29'b0, MEM_FUNCT3, MEM_WDATA}, 64'b0);
            end
        end
    end

    task automatic exp_wr(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        wr_t t;
        t.addr = a; t.f3 = f3; t.wdata = wd;
        wr_q.push_back(t);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge CLK);
        while (!REQ_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got ready=0 expected 1");
        end
    endtask

    // lat == 0 means no response is expected for this request.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic eerr,
                         input logic [31:0] erd, input int lat);
        resp_t t;
        wait_ready();
        REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = a; REQ_WDATA = wd;
        if (lat > 0) begin
            t.err = eerr; t.rdata = erd; t.cyc0 = cyc; t.lat = lat;
            exp_q.push_back(t);
        end
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_resp_q", 64'(exp_q.size()), 64'd0);
        chk("drain_wr_q", 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resp_t t;
        int low;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", 64'(REQ_READY), 64'd0);
        chk("rst_resp_valid", 64'(RESP_VALID), 64'd0);
        chk("rst_resp_rdata", 64'(RESP_RDATA), 64'd0);
        chk("rst_resp_err", 64'(RESP_ERR), 64'd0);
        chk("rst_mem_we", 64'(MEM_WE), 64'd0);
        @(posedge CLK);
        #1 RST = 1'b0; tb_init = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", 64'(REQ_READY), 64'd1);
        chk("post_rst_mem_addr", 64'(MEM_ADDR), 64'd0);
        mon_en = 1'b1;

        // 1: word store and load back
        exp_wr(32'h10, 3'b010, 32'h11223344);
        issue(1, 3'b010, 32'h10, 32'h11223344, 0, 32'h0, 2);
        issue(0, 3'b010, 32'h10, 32'h0, 0, 32'h11223344, 2);

        // 2: byte loads, byte store, signed/unsigned byte reads
        issue(0, 3'b000, 32'h10, 32'h0, 0, 32'h00000011, 2);
        issue(0, 3'b000, 32'h13, 32'h0, 0, 32'h00000044, 2);
        exp_wr(32'h12, 3'b000, 32'h000000FF);
        issue(1, 3'b000, 32'h12, 32'hFFFFFFFF, 0, 32'h0, 2);
        issue(0, 3'b000, 32'h12, 32'h0, 0, 32'hFFFFFFFF, 2);
        issue(0, 3'b100, 32'h12, 32'h0, 0, 32'h000000FF, 2);

        // 3: halfword store as two byte writes, then halfword loads
        exp_wr(32'h20, 3'b000, 32'h00000080);
        exp_wr(32'h21, 3'b000, 32'h00000001);
        issue(1, 3'b001, 32'h20, 32'hABCD8001, 0, 32'h0, 3);
        issue(0, 3'b001, 32'h20, 32'h0, 0, 32'hFFFF8001, 2);
        issue(0, 3'b101, 32'h20, 32'h0, 0, 32'h00008001, 2);

        // 4: rejected requests, then range boundary
        issue(0, 3'b010, 32'h22, 32'h0, 1, 32'h0, 1);
        issue(1, 3'b001, 32'h21, 32'h5555, 1, 32'h0, 1);
        issue(0, 3'b010, 32'h3FE, 32'h0, 1, 32'h0, 1);
        issue(0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1);
        issue(1, 3'b100, 32'h10, 32'h1, 1, 32'h0, 1);
        issue(1, 3'b000, 32'h401, 32'h1, 1, 32'h0, 1);
        issue(0, 3'b000, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 1);
        issue(0, 3'b000, 32'h400, 32'h0, 0, 32'h0, 2);
        exp_wr(32'h400, 3'b000, 32'h0000005A);
        issue(1, 3'b000, 32'h400, 32'h0000005A, 0, 32'h0, 2);
        issue(0, 3'b100, 32'h400, 32'h0, 0, 32'h0000005A, 2);
        issue(0, 3'b000, 32'h400, 32'h0, 0, 32'h0000005A, 2);
        drain();

        // 5: REQ_VALID held while busy with wandering request fields
        exp_wr(32'h40, 3'b000, 32'h00000056);
        exp_wr(32'h41, 3'b000, 32'h00000078);
        wait_ready();
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_FUNCT3 = 3'b001;
        REQ_ADDR = 32'h40; REQ_WDATA = 32'h00005678;
        t.err = 0; t.rdata = 32'h0; t.cyc0 = cyc; t.lat = 3;
        exp_q.push_back(t);
        @(posedge CLK);
        #1 REQ_ADDR = 32'h200; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010; REQ_WDATA = 32'hDEADBEEF;
        low = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (REQ_READY) break;
            low++;
            REQ_ADDR = 32'h100 + 32'(i * 4);
        end
        chk("ready_low_cycles", 64'(low), 64'd3);
        REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h40;
        t.err = 0; t.rdata = 32'h56780000; t.cyc0 = cyc; t.lat = 2;
        exp_q.push_back(t);
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        drain();

        // 6: reset during the second write of a halfword store
        exp_wr(32'h30, 3'b000, 32'h00000012);
        issue(1, 3'b001, 32'h30, 32'h00001234, 0, 32'h0, 0);
        @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        chk("rst_st1_mem_we", 64'(MEM_WE), 64'd0);
        chk("rst_st1_resp_valid", 64'(RESP_VALID), 64'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", 64'(REQ_READY), 64'd1);
        issue(0, 3'b000, 32'h30, 32'h0, 0, 32'h00000012, 2);
        issue(0, 3'b100, 32'h31, 32'h0, 0, 32'h00000000, 2);
        issue(0, 3'b001, 32'h30, 32'h0, 0, 32'h00001200, 2);
        drain();

        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
